// File: rtl/mem_out_streamer.sv
`default_nettype none
// ============================================================================
// Module   : mem_out_streamer
// Brief    : Show-ahead FIFO feeding a video AXI4-Stream master with tuser
//            (start of frame) / tlast (end of line) markers and a frame-done
//            pulse. Optional underrun counter under MEM_OUT_UNDERRUN_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_out_streamer #(
    parameter int WIDTH      = 1080,
    parameter int HEIGHT     = 960,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Pix_Valid,
    input  logic [DATA_W-1:0] Pix_Data,
    output logic              Pix_Ready,
    output logic [DATA_W-1:0] AXIS_Out_tdata,
    output logic              AXIS_Out_tvalid,
    input  logic              AXIS_Out_tready,
    output logic              AXIS_Out_tlast,
    output logic              AXIS_Out_tuser,
`ifdef MEM_OUT_UNDERRUN_CNT_EN
    output logic [15:0]       Underrun_Count,
`endif
    output logic              Frame_Done
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam int c_CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int c_RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(HEIGHT - 1);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_col;
    logic [c_RW-1:0]   r_row;
    logic              r_frame_done;

    logic w_empty;
    logic w_full;
    logic w_wr_en;
    logic w_rd_en;
    logic w_col_last;
    logic w_frame_end;

    // Same index bits with differing wrap bits means the writer lapped the reader.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                         (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_wr_en     = Pix_Valid && !w_full;
    assign w_rd_en     = !w_empty && AXIS_Out_tready;
    assign w_col_last  = (r_col == c_COL_LAST);
    assign w_frame_end = w_rd_en && w_col_last && (r_row == c_ROW_LAST);

    assign Pix_Ready       = !w_full;
    assign AXIS_Out_tvalid = !w_empty;
    assign AXIS_Out_tdata  = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];
    assign AXIS_Out_tlast  = !w_empty && w_col_last;
    assign AXIS_Out_tuser  = !w_empty && (r_col == '0) && (r_row == '0);
    assign Frame_Done      = r_frame_done;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= Pix_Data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_rd_en) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + c_RW'(1);
                end else begin
                    r_col <= r_col + c_CW'(1);
                end
            end
        end
    end

`ifdef MEM_OUT_UNDERRUN_CNT_EN
    logic        r_in_frame;
    logic [15:0] r_underrun;

    // In-frame spans from the first beat of a frame up to its final beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_frame <= 1'b0;
            r_underrun <= '0;
        end else begin
            if (w_rd_en) begin
                r_in_frame <= !w_frame_end;
            end
            if (AXIS_Out_tready && w_empty && r_in_frame && (r_underrun != 16'hFFFF)) begin
                r_underrun <= r_underrun + 16'd1;
            end
        end
    end

    assign Underrun_Count = r_underrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_out_streamer.sv
`default_nettype none
// Testbench for mem_out_streamer: randomized and directed stimulus checked
// against a queue-based reference model of the pixel stream.
module tb_mem_out_streamer;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pv = 1'b0;
    logic [DW-1:0] pd = '0;
    logic          pr;
    logic [DW-1:0] td;
    logic          tv;
    logic          tr = 1'b0;
    logic          tl;
    logic          tu;
    logic          fd;
`ifdef MEM_OUT_UNDERRUN_CNT_EN
    logic [15:0]   uc;
`endif

    mem_out_streamer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .Pix_Valid       (pv),
        .Pix_Data        (pd),
        .Pix_Ready       (pr),
        .AXIS_Out_tdata  (td),
        .AXIS_Out_tvalid (tv),
        .AXIS_Out_tready (tr),
        .AXIS_Out_tlast  (tl),
        .AXIS_Out_tuser  (tu),
`ifdef MEM_OUT_UNDERRUN_CNT_EN
        .Underrun_Count  (uc),
`endif
        .Frame_Done      (fd)
    );

    always #5 clk = ~clk;

    // Reference model: queue of stored pixels plus beat position within the frame.
    logic [DW-1:0] q[$];
    int            beat_idx = 0;
    bit            exp_fd = 0;
    int            ur = 0;
    bit            last_acc = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic model_reset();
        q.delete();
        beat_idx = 0;
        exp_fd   = 0;
        ur       = 0;
    endtask

    // Advance one clock edge, updating the model from the driven inputs.
    task automatic cyc();
        bit acc;
        bit beat;
        @(posedge clk);
        if (reset) begin
            acc  = pv && (q.size() < DEPTH);
            beat = tr && (q.size() > 0);
            if (tr && q.size() == 0 && beat_idx != 0 && ur < 65535) ur++;
            exp_fd = beat && (beat_idx == W*H - 1);
            if (beat) begin
                void'(q.pop_front());
                beat_idx = (beat_idx + 1) % (W*H);
            end
            if (acc) q.push_back(pd);
            last_acc = acc;
        end else begin
            last_acc = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pv = 1'($urandom); pd = DW'($urandom); tr = 1'($urandom);
            cyc();
            checks++;
            if (pr !== 1'b1 || tv !== 1'b0 || td !== '0 || tl !== 1'b0 || tu !== 1'b0 || fd !== 1'b0) begin
                errors++;
                $display("FAIL reset_vals: ready=%b valid=%b data=%h last=%b user=%b done=%b, required 1 0 0000 0 0 0",
                         pr, tv, td, tl, tu, fd);
            end
`ifdef MEM_OUT_UNDERRUN_CNT_EN
            checks++;
            if (uc !== 16'd0) begin
                errors++;
                $display("FAIL reset_underrun: got %0d required 0", uc);
            end
`endif
        end
        model_reset();
        pv = 1'b0; tr = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_small_frame();
        int fd_seen = 0;
        tr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pv = (i < 16);
            pd = DW'(i % 8);
            cyc();
            if (fd) fd_seen++;
            if (i == 0) begin
                checks++;
                if (tv !== 1'b1 || td !== 16'd0 || tu !== 1'b1) begin
                    errors++;
                    $display("FAIL sf_latency: valid=%b data=%h user=%b, required 1 0000 1", tv, td, tu);
                end
            end
            checks++;
            if (tv !== (q.size() > 0) || pr !== (q.size() < DEPTH) || fd !== exp_fd) begin
                errors++;
                $display("FAIL sf_ctrl: valid=%b ready=%b done=%b, required %b %b %b",
                         tv, pr, fd, q.size() > 0, q.size() < DEPTH, exp_fd);
            end
            if (q.size() > 0) begin
                checks++;
                if (td !== q[0] || tu !== (beat_idx == 0) || tl !== (beat_idx % W == W-1)) begin
                    errors++;
                    $display("FAIL sf_beat: data=%h user=%b last=%b, required %h %b %b",
                             td, tu, tl, q[0], beat_idx == 0, beat_idx % W == W-1);
                end
            end
        end
        checks++;
        if (fd_seen != 2) begin
            errors++;
            $display("FAIL sf_done_count: got %0d pulses required 2", fd_seen);
        end
        pv = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] h_d;
        logic          h_l;
        logic          h_u;
        logic [DW-1:0] nxt = 16'h0200;
        tr = 1'b1; pv = 1'b1; pd = nxt;
        for (int i = 0; i < 40; i++) begin
            if (i == W + 1) begin
                tr = 1'b0;
                h_d = td; h_l = tl; h_u = tu;
            end
            if (i == W + 6) tr = 1'b1;
            if (i == W + 10) pv = 1'b0;
            cyc();
            if (last_acc) nxt++;
            pd = nxt;
            if (i >= W + 1 && i < W + 6) begin
                checks++;
                if (tv !== 1'b1 || td !== h_d || tl !== h_l || tu !== h_u) begin
                    errors++;
                    $display("FAIL bp_hold: valid=%b data=%h last=%b user=%b, required 1 %h %b %b",
                             tv, td, tl, tu, h_d, h_l, h_u);
                end
            end
            checks++;
            if (tv !== (q.size() > 0) || pr !== (q.size() < DEPTH) || fd !== exp_fd) begin
                errors++;
                $display("FAIL bp_ctrl: valid=%b ready=%b done=%b, required %b %b %b",
                         tv, pr, fd, q.size() > 0, q.size() < DEPTH, exp_fd);
            end
            if (q.size() > 0) begin
                checks++;
                if (td !== q[0] || tu !== (beat_idx == 0) || tl !== (beat_idx % W == W-1)) begin
                    errors++;
                    $display("FAIL bp_beat: data=%h user=%b last=%b, required %h %b %b",
                             td, tu, tl, q[0], beat_idx == 0, beat_idx % W == W-1);
                end
            end
        end
    endtask

    task automatic test_full();
        logic [DW-1:0] nxt = 16'h0100;
        pv = 1'b0; tr = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) cyc();
        tr = 1'b0; pv = 1'b1; pd = nxt;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (last_acc) nxt++;
            pd = nxt;
            checks++;
            if (pr !== (q.size() < DEPTH) || tv !== (q.size() > 0)) begin
                errors++;
                $display("FAIL full_ready: ready=%b valid=%b, required %b %b",
                         pr, tv, q.size() < DEPTH, q.size() > 0);
            end
        end
        checks++;
        if (pr !== 1'b0 || td !== 16'h0100) begin
            errors++;
            $display("FAIL full_state: ready=%b head=%h, required 0 0100", pr, td);
        end
        tr = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (last_acc) nxt++;
            if (nxt == 16'h0114) pv = 1'b0;
            pd = nxt;
            checks++;
            if (tv !== (q.size() > 0) || pr !== (q.size() < DEPTH) || fd !== exp_fd) begin
                errors++;
                $display("FAIL full_ctrl: valid=%b ready=%b done=%b, required %b %b %b",
                         tv, pr, fd, q.size() > 0, q.size() < DEPTH, exp_fd);
            end
            if (q.size() > 0) begin
                checks++;
                if (td !== q[0] || tu !== (beat_idx == 0) || tl !== (beat_idx % W == W-1)) begin
                    errors++;
                    $display("FAIL full_beat: data=%h user=%b last=%b, required %h %b %b",
                             td, tu, tl, q[0], beat_idx == 0, beat_idx % W == W-1);
                end
            end
        end
        checks++;
        if (nxt != 16'h0114 || tv !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: accepted up to %h valid=%b, required 0114 0", nxt, tv);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            pv = ($urandom_range(0, 3) != 0);
            tr = ($urandom_range(0, 2) != 0);
            pd = DW'($urandom);
            cyc();
            checks++;
            if (tv !== (q.size() > 0) || pr !== (q.size() < DEPTH) || fd !== exp_fd) begin
                errors++;
                $display("FAIL rnd_ctrl: valid=%b ready=%b done=%b, required %b %b %b",
                         tv, pr, fd, q.size() > 0, q.size() < DEPTH, exp_fd);
            end
            if (q.size() > 0) begin
                checks++;
                if (td !== q[0] || tu !== (beat_idx == 0) || tl !== (beat_idx % W == W-1)) begin
                    errors++;
                    $display("FAIL rnd_beat: data=%h user=%b last=%b, required %h %b %b",
                             td, tu, tl, q[0], beat_idx == 0, beat_idx % W == W-1);
                end
            end
`ifdef MEM_OUT_UNDERRUN_CNT_EN
            checks++;
            if (uc !== 16'(ur)) begin
                errors++;
                $display("FAIL rnd_underrun: got %0d required %0d", uc, ur);
            end
`endif
        end
        pv = 1'b0;
    endtask

`ifdef MEM_OUT_UNDERRUN_CNT_EN
    task automatic test_underrun();
        reset = 1'b0;
        cyc();
        model_reset();
        reset = 1'b1;
        tr = 1'b1; pv = 1'b0;
        for (int i = 0; i < 22; i++) begin
            pv = (i >= 3 && i < 5) || (i >= 8 && i < 14);
            pd = DW'(i);
            cyc();
            checks++;
            if (uc !== 16'(ur)) begin
                errors++;
                $display("FAIL ur_track: got %0d required %0d", uc, ur);
            end
        end
        checks++;
        if (uc !== 16'd3) begin
            errors++;
            $display("FAIL ur_total: got %0d required 3", uc);
        end
        pv = 1'b0;
    endtask
`endif

    task automatic test_mid_reset();
        logic [DW-1:0] nxt = 16'h0300;
        tr = 1'b1; pv = 1'b1; pd = nxt;
        for (int i = 0; i < 60 && !(beat_idx == W + 2 && q.size() > 0); i++) begin
            cyc();
            if (last_acc) nxt++;
            pd = nxt;
        end
        checks++;
        if (tv !== 1'b1 || tu !== 1'b0) begin
            errors++;
            $display("FAIL mr_position: valid=%b user=%b, required 1 0", tv, tu);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (tv !== 1'b0 || tu !== 1'b0 || tl !== 1'b0 || pr !== 1'b1 || fd !== 1'b0 || td !== '0) begin
            errors++;
            $display("FAIL mr_async_clear: valid=%b user=%b last=%b ready=%b done=%b data=%h, required 0 0 0 1 0 0000",
                     tv, tu, tl, pr, fd, td);
        end
        model_reset();
        pv = 1'b0;
        cyc();
        reset = 1'b1;
        pv = 1'b1; pd = 16'hABCD;
        cyc();
        pv = 1'b0;
        checks++;
        if (tv !== 1'b1 || tu !== 1'b1 || tl !== 1'b0 || td !== 16'hABCD) begin
            errors++;
            $display("FAIL mr_first_beat: valid=%b user=%b last=%b data=%h, required 1 1 0 abcd",
                     tv, tu, tl, td);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (tv !== (q.size() > 0) || fd !== exp_fd) begin
                errors++;
                $display("FAIL mr_after: valid=%b done=%b, required %b %b", tv, fd, q.size() > 0, exp_fd);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_small_frame();
        test_backpressure();
        test_full();
        test_random();
`ifdef MEM_OUT_UNDERRUN_CNT_EN
        test_underrun();
`endif
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
